instruct_loader: RTL and testbench

Byte-stream program loader that fills instruction memory before the CPU runs. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It issues one write per word on the instruction-memory write port (byte address, stepping by 4) and validates a trailing checksum. The CPU is held in reset via `CpuHold` for the whole load.

---
 rtl/instruct_loader_pkg.sv | 20 ++
 rtl/instruct_loader_byte_packer.sv | 36 +++
 rtl/instruct_loader.sv | 121 ++++++++++++
 tb/tb_instruct_loader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruct_loader_pkg.sv
// instruct_loader_pkg: state encoding, default geometry and length check for the program loader
package instruct_loader_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_HI = 3'd1;
    localparam logic [2:0] LEN_LO = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam int          DEFAULT_DEPTH     = 256;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0;

    // A word count is usable only if it is non-zero and fits in instruction memory
    function automatic logic lenIllegal(input logic [15:0] n, input int depth);
        return (n == 16'd0) || (int'(n) > depth);
    endfunction

endpackage

// File: rtl/instruct_loader_byte_packer.sv
// byte_packer: shifts stream bytes MSB-first into a 32-bit word and flags each completed word for one cycle
module byte_packer (
    input  logic        clk,
    input  logic        rstN,
    input  logic        clear,
    input  logic        byteEn,
    input  logic [7:0]  byteIn,
    output logic        lastLane,
    output logic        wordValid,
    output logic [31:0] word
);

    logic [1:0] lane;

    assign lastLane = lane == 2'd3;

    // Shift in bytes; the word is complete (and stays stable) in the cycle after its 4th byte
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lane      <= 2'd0;
            word      <= 32'd0;
            wordValid <= 1'b0;
        end else if (clear) begin
            lane      <= 2'd0;
            word      <= 32'd0;
            wordValid <= 1'b0;
        end else begin
            wordValid <= byteEn && lastLane;
            if (byteEn) begin
                word <= {word[23:0], byteIn};
                lane <= lane + 2'd1;
            end
        end
    end

endmodule

// File: rtl/instruct_loader.sv
// instruct_loader: framed byte-stream loader that writes big-endian words into instruction memory and checks a trailing checksum
module instruct_loader
    import instruct_loader_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        Start,
    input  logic        ByteValid,
    input  logic [7:0]  ByteData,
    output logic        ByteReady,
    output logic        ImemWrEn,
    output logic [31:0] ImemWrAddr,
    output logic [31:0] ImemWrData,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error
);

    logic [2:0]  state;
    logic [2:0]  nextState;
    logic [7:0]  lenHi;
    logic [15:0] wordCount;
    logic [15:0] wordsIn;
    logic [15:0] wrIdx;
    logic [7:0]  chkAcc;
    logic [15:0] lenValue;
    logic        accept;
    logic        startLoad;
    logic        lastLane;
    logic        wordValid;
    logic [31:0] word;

    assign accept    = ByteValid && ByteReady;
    assign startLoad = (state == IDLE) && Start;
    assign lenValue  = {lenHi, ByteData};

    byte_packer packer (
        .clk       (CLK),
        .rstN      (RST_n),
        .clear     (startLoad),
        .byteEn    (accept && (state == DATA)),
        .byteIn    (ByteData),
        .lastLane  (lastLane),
        .wordValid (wordValid),
        .word      (word)
    );

    // State register; reset aborts any load in progress
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Frame sequencing: header, N words, checksum; DONE and ERR last one cycle
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = Start ? LEN_HI : IDLE;
            LEN_HI:  nextState = accept ? LEN_LO : LEN_HI;
            LEN_LO:  nextState = !accept ? LEN_LO : (lenIllegal(lenValue, DEPTH) ? ERR : DATA);
            DATA:    nextState = (accept && lastLane && (wordsIn == wordCount - 16'd1)) ? CHECK : DATA;
            CHECK:   nextState = !accept ? CHECK : ((ByteData == chkAcc) ? DONE : ERR);
            default: nextState = IDLE;
        endcase
    end

    // Handshake, hold and status outputs decoded from the current state and the packer
    always_comb begin
        ByteReady  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CHECK);
        CpuHold    = state != IDLE;
        Done       = state == DONE;
        ImemWrEn   = wordValid;
        ImemWrData = word;
        ImemWrAddr = BASE_ADDR + {14'd0, wrIdx, 2'b00};
    end

    // Length capture, word counters, checksum and the sticky error flag
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            lenHi     <= 8'd0;
            wordCount <= 16'd0;
            wordsIn   <= 16'd0;
            wrIdx     <= 16'd0;
            chkAcc    <= 8'd0;
            Error     <= 1'b0;
        end else begin
            if (startLoad) begin
                wordsIn <= 16'd0;
                wrIdx   <= 16'd0;
                chkAcc  <= 8'd0;
                Error   <= 1'b0;
            end
            if ((state == LEN_HI) && accept) begin
                lenHi <= ByteData;
            end
            if ((state == LEN_LO) && accept) begin
                wordCount <= lenValue;
            end
            if ((state == DATA) && accept) begin
                chkAcc <= chkAcc + ByteData;
                if (lastLane) begin
                    wordsIn <= wordsIn + 16'd1;
                end
            end
            // The address index parks on the last word so it never points past the loaded image
            if (wordValid && (wrIdx != wordCount - 16'd1)) begin
                wrIdx <= wrIdx + 16'd1;
            end
            if (nextState == ERR) begin
                Error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruct_loader.sv
// tb_instruct_loader: directed self-checking bench for the instruction loader
module tb_instruct_loader;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        Start = 1'b0;
    logic        ByteValid = 1'b0;
    logic [7:0]  ByteData = 8'd0;
    logic        ByteReady;
    logic        ImemWrEn;
    logic [31:0] ImemWrAddr;
    logic [31:0] ImemWrData;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wrCnt = 0;
    int doneCnt = 0;
    int doneCyc = 0;
    logic [31:0] wAddr [0:1023];
    logic [31:0] wData [0:1023];
    int          wCyc  [0:1023];
    logic [31:0] words [0:299];

    always #5 CLK = ~CLK;

    instruct_loader #(.DEPTH(256), .BASE_ADDR(32'h0)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .Start      (Start),
        .ByteValid  (ByteValid),
        .ByteData   (ByteData),
        .ByteReady  (ByteReady),
        .ImemWrEn   (ImemWrEn),
        .ImemWrAddr (ImemWrAddr),
        .ImemWrData (ImemWrData),
        .CpuHold    (CpuHold),
        .Done       (Done),
        .Error      (Error)
    );

    always @(posedge CLK) cyc <= cyc + 1;

    // Record every write and Done pulse away from the active edge
    always @(negedge CLK) begin
        if (ImemWrEn && wrCnt < 1024) begin
            wAddr[wrCnt] = ImemWrAddr;
            wData[wrCnt] = ImemWrData;
            wCyc[wrCnt]  = cyc;
            wrCnt++;
        end
        if (Done) begin
            doneCnt++;
            doneCyc = cyc;
        end
    end

    task automatic doStart;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int t = 0;
        ByteValid = 1'b1;
        ByteData  = b;
        while (!ByteReady && t < 16) begin
            @(negedge CLK);
            t++;
        end
        if (!ByteReady) begin
            tests++;
            fails++;
            $display("FAIL byte_accept_timeout: ByteReady=%0b required 1", ByteReady);
        end
        @(negedge CLK);
        ByteValid = 1'b0;
    endtask

    task automatic sendFrame(input int n, input int chkAdj, input bit gaps);
        logic [7:0] sum = 8'd0;
        logic [7:0] b8;
        doStart();
        sendByte(8'(n >> 8));
        sendByte(8'(n));
        if (n >= 1 && n <= 256) begin
            for (int k = 0; k < n; k++) begin
                for (int b = 0; b < 4; b++) begin
                    b8 = 8'(words[k] >> (24 - 8 * b));
                    sum = sum + b8;
                    if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
                    if (gaps && k == 1 && b == 0) begin
                        Start = 1'b1;
                        @(negedge CLK);
                        Start = 1'b0;
                    end
                    sendByte(b8);
                end
            end
            sendByte(sum + 8'(chkAdj));
        end
    endtask

    task automatic waitIdle;
        int t = 0;
        while (CpuHold && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (CpuHold) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: CpuHold=%0b required 0", CpuHold);
        end
    endtask

    task automatic test_reset;
        #12;
        tests++;
        if ({ByteReady, ImemWrEn, CpuHold, Done, Error} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b required 00000", {ByteReady, ImemWrEn, CpuHold, Done, Error});
        end
        tests++;
        if (ImemWrAddr !== 32'h0) begin
            fails++;
            $display("FAIL reset_addr: got %h required 00000000", ImemWrAddr);
        end
        tests++;
        if (ImemWrData !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got %h required 00000000", ImemWrData);
        end
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_word;
        int base = wrCnt;
        int d0 = doneCnt;
        int sc = cyc;
        words[0] = 32'hDEADBEEF;
        sendFrame(1, 0, 1'b0);
        waitIdle();
        tests++;
        if (wrCnt - base !== 1) begin
            fails++;
            $display("FAIL single_write_count: got %0d required 1", wrCnt - base);
        end
        tests++;
        if (wAddr[base] !== 32'h0 || wData[base] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_write: got %h/%h required 00000000/deadbeef", wAddr[base], wData[base]);
        end
        tests++;
        if (wCyc[base] - sc !== 7) begin
            fails++;
            $display("FAIL single_write_latency: got %0d required 7", wCyc[base] - sc);
        end
        tests++;
        if (doneCnt - d0 !== 1 || doneCyc - sc !== 8) begin
            fails++;
            $display("FAIL single_done: got count %0d at %0d required 1 at 8", doneCnt - d0, doneCyc - sc);
        end
        tests++;
        if (Error !== 1'b0 || CpuHold !== 1'b0) begin
            fails++;
            $display("FAIL single_status: got Error=%0b CpuHold=%0b required 0 0", Error, CpuHold);
        end
    endtask

    task automatic test_full_depth;
        int base = wrCnt;
        int d0 = doneCnt;
        int sc = cyc;
        int bad = 0;
        int badGap = 0;
        for (int k = 0; k < 256; k++) words[k] = k;
        sendFrame(256, 0, 1'b0);
        waitIdle();
        tests++;
        if (wrCnt - base !== 256) begin
            fails++;
            $display("FAIL full_write_count: got %0d required 256", wrCnt - base);
        end
        for (int k = 0; k < 256; k++) begin
            if (wAddr[base + k] !== 32'(4 * k) || wData[base + k] !== 32'(k)) bad++;
            if (k > 0 && wCyc[base + k] - wCyc[base + k - 1] !== 4) badGap++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL full_write_contents: got %0d wrong writes required 0", bad);
        end
        tests++;
        if (badGap !== 0) begin
            fails++;
            $display("FAIL full_write_spacing: got %0d irregular gaps required 0", badGap);
        end
        tests++;
        if (doneCnt - d0 !== 1 || doneCyc - sc !== 1028 || Error !== 1'b0) begin
            fails++;
            $display("FAIL full_done: got count %0d at %0d Error=%0b required 1 at 1028 Error=0", doneCnt - d0, doneCyc - sc, Error);
        end
    endtask

    task automatic test_bad_len(input int n, input string name);
        int base = wrCnt;
        int d0 = doneCnt;
        sendFrame(n, 0, 1'b0);
        tests++;
        if (Error !== 1'b1 || ByteReady !== 1'b0) begin
            fails++;
            $display("FAIL %s_err_state: got Error=%0b ByteReady=%0b required 1 0", name, Error, ByteReady);
        end
        waitIdle();
        tests++;
        if (Error !== 1'b1 || CpuHold !== 1'b0 || wrCnt !== base || doneCnt !== d0) begin
            fails++;
            $display("FAIL %s_after: got Error=%0b CpuHold=%0b writes=%0d done=%0d required 1 0 0 0", name, Error, CpuHold, wrCnt - base, doneCnt - d0);
        end
    endtask

    task automatic test_bad_chk_retry;
        int base = wrCnt;
        int d0 = doneCnt;
        words[0] = 32'h12345678;
        words[1] = 32'h9ABCDEF0;
        sendFrame(2, 1, 1'b0);
        waitIdle();
        repeat (3) @(negedge CLK);
        tests++;
        if (wrCnt - base !== 2 || wData[base] !== 32'h12345678 || wData[base + 1] !== 32'h9ABCDEF0 || wAddr[base + 1] !== 32'h4) begin
            fails++;
            $display("FAIL badchk_writes: got %0d writes %h %h required 2 writes 12345678 9abcdef0", wrCnt - base, wData[base], wData[base + 1]);
        end
        tests++;
        if (Error !== 1'b1 || doneCnt !== d0) begin
            fails++;
            $display("FAIL badchk_status: got Error=%0b done=%0d required 1 0", Error, doneCnt - d0);
        end
        doStart();
        tests++;
        if (Error !== 1'b0 || CpuHold !== 1'b1) begin
            fails++;
            $display("FAIL retry_clear: got Error=%0b CpuHold=%0b required 0 1", Error, CpuHold);
        end
        @(negedge CLK);
        RST_n = 1'b1;
        base = wrCnt;
        sendByte(8'h00);
        sendByte(8'h02);
        for (int k = 0; k < 2; k++) for (int b = 0; b < 4; b++) sendByte(8'(words[k] >> (24 - 8 * b)));
        sendByte(8'h12 + 8'h34 + 8'h56 + 8'h78 + 8'h9A + 8'hBC + 8'hDE + 8'hF0);
        waitIdle();
        tests++;
        if (doneCnt - d0 !== 1 || Error !== 1'b0 || wrCnt - base !== 2 || wAddr[base] !== 32'h0) begin
            fails++;
            $display("FAIL retry_done: got done=%0d Error=%0b writes=%0d addr0=%h required 1 0 2 00000000", doneCnt - d0, Error, wrCnt - base, wAddr[base]);
        end
    endtask

    task automatic test_reset_mid_load;
        int base;
        int d0;
        doStart();
        sendByte(8'h00);
        sendByte(8'h02);
        for (int i = 0; i < 6; i++) sendByte(8'(8'h11 * (i + 1)));
        #2;
        RST_n = 1'b0;
        #1;
        tests++;
        if ({ByteReady, ImemWrEn, CpuHold, Done, Error} !== 5'b0 || ImemWrAddr !== 32'h0 || ImemWrData !== 32'h0) begin
            fails++;
            $display("FAIL midreset_outputs: got %b %h %h required 00000 00000000 00000000", {ByteReady, ImemWrEn, CpuHold, Done, Error}, ImemWrAddr, ImemWrData);
        end
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        base = wrCnt;
        d0 = doneCnt;
        words[0] = 32'hCAFEF00D;
        sendFrame(1, 0, 1'b0);
        waitIdle();
        tests++;
        if (wrCnt - base !== 1 || wAddr[base] !== 32'h0 || wData[base] !== 32'hCAFEF00D || doneCnt - d0 !== 1) begin
            fails++;
            $display("FAIL midreset_reload: got %0d writes %h/%h done=%0d required 1 00000000/cafef00d 1", wrCnt - base, wAddr[base], wData[base], doneCnt - d0);
        end
    endtask

    task automatic test_gaps_and_start;
        int base = wrCnt;
        int d0 = doneCnt;
        int bad = 0;
        words[0] = 32'h01020304;
        words[1] = 32'hA5A55A5A;
        words[2] = 32'hFFFFFFFF;
        sendFrame(3, 0, 1'b1);
        waitIdle();
        tests++;
        if (wrCnt - base !== 3) begin
            fails++;
            $display("FAIL gaps_write_count: got %0d required 3", wrCnt - base);
        end
        for (int k = 0; k < 3; k++) if (wAddr[base + k] !== 32'(4 * k) || wData[base + k] !== words[k]) bad++;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL gaps_write_contents: got %0d wrong writes required 0", bad);
        end
        tests++;
        if (doneCnt - d0 !== 1 || Error !== 1'b0) begin
            fails++;
            $display("FAIL gaps_done: got done=%0d Error=%0b required 1 0", doneCnt - d0, Error);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_depth();
        test_bad_len(257, "len257");
        test_bad_len(0, "len0");
        test_bad_chk_retry();
        test_reset_mid_load();
        test_gaps_and_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
